// File: rtl/array_loader.sv
// Collects four switch values via debounced ENTER/DELETE buttons, presents them on X..W,
// then runs a START / DONE / CLR handshake with the bubble-sort controller.
module array_loader #(
   parameter logic [19:0] DEB_CNT = 20'd500000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] SW,
   input  logic       BTN_ENT,
   input  logic       BTN_DEL,
   input  logic       DONE,
   input  logic       CLR,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic [3:0] Z,
   output logic [3:0] W,
   output logic [2:0] COUNT,
   output logic       FULL,
   output logic       START,
   output logic       BUSY
);

   typedef enum logic [2:0] {S_FILL, S_READY, S_GO, S_WAIT, S_HOLD} state_t;

   logic [3:0] sw_meta_reg, sw_sync_reg;
   logic [1:0] btn_raw, btn_meta_reg, btn_sync_reg;
   logic [1:0] ev;
   logic       ent_ev, del_ev, ent_only, del_only;

   state_t     state_reg, state_next;
   logic [3:0] slot_reg [4];
   logic [3:0] slot_next [4];
   logic [2:0] count_reg, count_next;
   logic       full_reg, start_reg, busy_reg;

   assign btn_raw = {BTN_DEL, BTN_ENT};

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sw_meta_reg  <= '0;
         sw_sync_reg  <= '0;
         btn_meta_reg <= '0;
         btn_sync_reg <= '0;
      end else begin
         sw_meta_reg  <= SW;
         sw_sync_reg  <= sw_meta_reg;
         btn_meta_reg <= btn_raw;
         btn_sync_reg <= btn_meta_reg;
      end
   end

   // Bit 0 is ENTER, bit 1 is DELETE; each has its own counter and level.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_deb
         logic [19:0] cnt_reg;
         logic        deb_reg, deb_prev_reg, ev_reg;

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               cnt_reg      <= '0;
               deb_reg      <= 1'b0;
               deb_prev_reg <= 1'b0;
               ev_reg       <= 1'b0;
            end else begin
               deb_prev_reg <= deb_reg;
               ev_reg       <= deb_reg & ~deb_prev_reg;
               if (btn_sync_reg[gi] == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DEB_CNT - 20'd1) begin
                  deb_reg <= btn_sync_reg[gi];
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 20'd1;
               end
            end
         end

         assign ev[gi] = ev_reg;
      end
   endgenerate

   assign ent_ev   = ev[0];
   assign del_ev   = ev[1];
   assign ent_only = ent_ev & ~del_ev;
   assign del_only = del_ev & ~ent_ev;

   always_comb begin
      state_next = state_reg;
      slot_next  = slot_reg;
      count_next = count_reg;
      case (state_reg)
         S_FILL: begin
            if (ent_only) begin
               slot_next[count_reg[1:0]] = sw_sync_reg;
               count_next = count_reg + 3'd1;
               if (count_reg == 3'd3) begin
                  state_next = S_READY;
               end
            end else if (del_only && count_reg != 3'd0) begin
               count_next = count_reg - 3'd1;
               slot_next[count_next[1:0]] = 4'h0;
            end
         end
         S_READY: begin
            if (ent_only) begin
               state_next = S_GO;
            end else if (del_only) begin
               state_next   = S_FILL;
               count_next   = 3'd3;
               slot_next[3] = 4'h0;
            end
         end
         S_GO: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (DONE) begin
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (CLR) begin
               state_next = S_FILL;
               count_next = 3'd0;
               for (int i = 0; i < 4; i++) begin
                  slot_next[i] = 4'h0;
               end
            end
         end
         default: begin
            state_next = S_FILL;
         end
      endcase
   end

   // Status outputs are flops loaded from the next state, so they align with it.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_reg <= S_FILL;
         count_reg <= '0;
         full_reg  <= 1'b0;
         start_reg <= 1'b0;
         busy_reg  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            slot_reg[i] <= 4'h0;
         end
      end else begin
         state_reg <= state_next;
         slot_reg  <= slot_next;
         count_reg <= count_next;
         full_reg  <= (state_next == S_READY);
         start_reg <= (state_next == S_GO);
         busy_reg  <= (state_next == S_WAIT);
      end
   end

   assign X     = slot_reg[0];
   assign Y     = slot_reg[1];
   assign Z     = slot_reg[2];
   assign W     = slot_reg[3];
   assign COUNT = count_reg;
   assign FULL  = full_reg;
   assign START = start_reg;
   assign BUSY  = busy_reg;

endmodule
